// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and constants for the EX-stage multiply/divide unit.
// Build option: define MULDIV_DIV_EN to include the DIV state and divide datapath.
package muldiv_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_FIX  = 2'd3
  } muldiv_state_e;

  // Magnitude of a signed operand; unsigned ops pass through untouched.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// One combinational iteration on {acc, lo}: shift-add multiply or restoring divide.
// Build option: MULDIV_DIV_EN adds the divide step and its select input.
module ex_muldiv_step (
`ifdef MULDIV_DIV_EN
  input  logic        is_div,
`endif
  input  logic [31:0] acc,
  input  logic [31:0] lo,
  input  logic [31:0] opnd,
  output logic [31:0] acc_nxt,
  output logic [31:0] lo_nxt
);

  logic [32:0] sum;
`ifdef MULDIV_DIV_EN
  logic [32:0] rem_sh;
  logic [32:0] trial;
`endif

  always_comb begin
    // Multiply: lo holds the multiplier, consumed LSB first as the product shifts in.
    sum     = lo[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
    acc_nxt = sum[32:1];
    lo_nxt  = {sum[0], lo[31:1]};
`ifdef MULDIV_DIV_EN
    rem_sh = {acc, lo[31]};
    trial  = rem_sh - {1'b0, opnd};
    if (is_div) begin
      if (!trial[32]) begin
        acc_nxt = trial[31:0];
        lo_nxt  = {lo[30:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[31:0];
        lo_nxt  = {lo[30:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage iterative multiply/divide controller with architectural HI/LO.
// Build option: MULDIV_DIV_EN enables DIV/DIVU; otherwise they decode as NOP.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [3:0]  i_op,
  input  logic [31:0] i_rs_data,
  input  logic [31:0] i_rt_data,
  output logic [31:0] o_result,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done
);

  muldiv_state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [31:0]   hi_q, hi_d, lor_q, lor_d;
  logic          neg_q, neg_d;
`ifdef MULDIV_DIV_EN
  logic          isdiv_q, isdiv_d, rneg_q, rneg_d, div0_q, div0_d;
`endif
  logic [31:0]   step_acc, step_lo;
  logic [63:0]   prod;
  logic          op_mul, op_div, op_sgn, op_act, accept;

  always_comb begin
    op_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
`ifdef MULDIV_DIV_EN
    op_div = (i_op == OP_DIV) || (i_op == OP_DIVU);
`else
    op_div = 1'b0;
`endif
    op_sgn = (i_op == OP_MULT) || (i_op == OP_DIV);
    op_act = op_mul || op_div || (i_op == OP_MFHI) || (i_op == OP_MFLO) ||
             (i_op == OP_MTHI) || (i_op == OP_MTLO);
  end

  assign accept   = i_valid && (op_mul || op_div) && (state_q == ST_IDLE);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_stall  = i_valid && op_act && o_busy;
  assign o_done   = (state_q == ST_FIX);
  assign o_hi     = hi_q;
  assign o_lo     = lor_q;
  assign o_result = (i_valid && !o_busy && i_op == OP_MFHI) ? hi_q :
                    (i_valid && !o_busy && i_op == OP_MFLO) ? lor_q : 32'd0;

  ex_muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .is_div  (state_q == ST_DIV),
`endif
    .acc     (acc_q),
    .lo      (lo_q),
    .opnd    (opnd_q),
    .acc_nxt (step_acc),
    .lo_nxt  (step_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lor_d   = lor_q;
    prod    = {acc_q, lo_q};
`ifdef MULDIV_DIV_EN
    isdiv_d = isdiv_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_MUL;
`ifdef MULDIV_DIV_EN
          if (op_div) state_d = ST_DIV;
          isdiv_d = op_div;
          rneg_d  = op_sgn && i_rs_data[31];
          div0_d  = op_div && (i_rt_data == 32'd0);
`endif
          cnt_d  = 5'd0;
          acc_d  = 32'd0;
          lo_d   = abs32(i_rs_data, op_sgn);
          opnd_d = abs32(i_rt_data, op_sgn);
          neg_d  = op_sgn && (i_rs_data[31] ^ i_rt_data[31]);
        end else if (i_valid && i_op == OP_MTHI) begin
          hi_d = i_rs_data;
        end else if (i_valid && i_op == OP_MTLO) begin
          lor_d = i_rs_data;
        end
      end
      ST_FIX: begin
        prod    = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
        hi_d    = prod[63:32];
        lor_d   = prod[31:0];
`ifdef MULDIV_DIV_EN
        // A zero divisor leaves |dividend| in acc, so the remainder sign fix restores the dividend.
        if (isdiv_q) begin
          hi_d  = rneg_q ? -acc_q : acc_q;
          lor_d = div0_q ? DIV0_LO : (neg_q ? -lo_q : lo_q);
        end
`endif
        state_d = ST_IDLE;
      end
      default: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_COUNT - 1)) state_d = ST_FIX;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 32'd0;
      lo_q    <= 32'd0;
      opnd_q  <= 32'd0;
      neg_q   <= 1'b0;
      hi_q    <= 32'd0;
      lor_q   <= 32'd0;
`ifdef MULDIV_DIV_EN
      isdiv_q <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lor_q   <= lor_d;
`ifdef MULDIV_DIV_EN
      isdiv_q <= isdiv_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
`endif
    end
  end

endmodule
